// File: rtl/mask_cfg_pkg.sv
// Shared types and constants for the luma mask configuration controller.
// Holds the profile record, field codes, reset defaults and FSM state codes.
package mask_cfg_pkg;

  localparam int NPROF = 3;

  // Register field codes on the configuration write/read port
  localparam logic [2:0] F_Y    = 3'd0;
  localparam logic [2:0] F_X1   = 3'd1;
  localparam logic [2:0] F_Y1   = 3'd2;
  localparam logic [2:0] F_X2   = 3'd3;
  localparam logic [2:0] F_Y2   = 3'd4;
  localparam logic [2:0] F_BX   = 3'd5;
  localparam logic [2:0] F_BY   = 3'd6;
  localparam logic [2:0] F_RSVD = 3'd7;

  // One mask profile: luma threshold, ROI window and minimum blob size
  typedef struct packed {
    logic [7:0] y;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [9:0] x2;
    logic [9:0] y2;
    logic [8:0] bx;
    logic [8:0] by;
  } prof_t;

  localparam prof_t PROF_DEFAULT [NPROF] = '{
    '{y: 8'd64, x1: 10'd55, y1: 10'd60, x2: 10'd660, y2: 10'd192, bx: 9'd21, by: 9'd15},
    '{y: 8'd64, x1: 10'd98, y1: 10'd96, x2: 10'd621, y2: 10'd196, bx: 9'd30, by: 9'd30},
    '{y: 8'd64, x1: 10'd11, y1: 10'd84, x2: 10'd709, y2: 10'd216, bx: 9'd30, by: 9'd30}
  };

  // Commit FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Zero-extended view of one field of a profile; reserved code reads as 0
  function automatic logic [9:0] get_field(prof_t p, logic [2:0] f);
    logic [9:0] r;
    r = 10'd0;
    case (f)
      F_Y:     r = {2'b00, p.y};
      F_X1:    r = p.x1;
      F_Y1:    r = p.y1;
      F_X2:    r = p.x2;
      F_Y2:    r = p.y2;
      F_BX:    r = {1'b0, p.bx};
      F_BY:    r = {1'b0, p.by};
      default: r = 10'd0;
    endcase
    return r;
  endfunction

  // Returns the profile with one field replaced; narrow fields drop upper data bits
  function automatic prof_t set_field(prof_t p, logic [2:0] f, logic [9:0] d);
    prof_t r;
    r = p;
    case (f)
      F_Y:     r.y  = d[7:0];
      F_X1:    r.x1 = d;
      F_Y1:    r.y1 = d;
      F_X2:    r.x2 = d;
      F_Y2:    r.y2 = d;
      F_BX:    r.bx = d[8:0];
      F_BY:    r.by = d[8:0];
      default: r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mask_cfg_ctrl_if.sv
// Configuration write port (valid/ready) for mask_cfg_ctrl.
interface mask_cfg_ctrl_if;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_prof;
  logic [2:0] cfg_field;
  logic [9:0] cfg_data;

  modport master (output cfg_valid, output cfg_prof, output cfg_field, output cfg_data,
                  input  cfg_ready);

  modport slave  (input  cfg_valid, input  cfg_prof, input  cfg_field, input  cfg_data,
                  output cfg_ready);

endinterface

// File: rtl/mask_cfg_check.sv
// Combinational ROI window validator: window must be non-empty and inside the active area.
module mask_cfg_check #(
  parameter int H_ACTIVE = 720,
  parameter int V_ACTIVE = 288
) (
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  input  logic [9:0] x2,
  input  logic [9:0] y2,
  output logic       ok
);

  assign ok = (x1 < x2) && (y1 < y2) &&
              ({22'd0, x2} < 32'(H_ACTIVE)) &&
              ({22'd0, y2} < 32'(V_ACTIVE));

endmodule

// File: rtl/mask_cfg_ctrl.sv
// Frame-synchronous configuration controller for the luma mask datapath.
// Register writes land in a staging bank; the selected profile is validated and
// copied to the active outputs only at frame start, so the datapath never sees a
// window change mid-frame.
// Optional readback port of the staging bank: define MASK_CFG_READBACK_EN.
module mask_cfg_ctrl
  import mask_cfg_pkg::*;
#(
  parameter int H_ACTIVE = 720,
  parameter int V_ACTIVE = 288
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [1:0]  sel_req,
  mask_cfg_ctrl_if.slave cfg,
  input  logic        err_clr,
  output logic        cfg_err,
  output logic        commit,
  output logic [1:0]  sel_active,
  output logic [7:0]  y_const,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [8:0]  blob_min_x,
  output logic [8:0]  blob_min_y,
  output logic [15:0] frame_cnt
`ifdef MASK_CFG_READBACK_EN
  ,
  input  logic        rd_req,
  input  logic [1:0]  rd_prof,
  input  logic [2:0]  rd_field,
  output logic [9:0]  rd_data,
  output logic        rd_valid
`endif
);

  logic       vs_d;
  logic       fs;
  logic [1:0] state;
  prof_t      stage [NPROF];
  prof_t      act;
  prof_t      cand;
  prof_t      sel_set;
  logic [1:0] cand_sel;
  logic       cand_ok;
  logic [1:0] sel_map;
  logic       chk_ok;
  logic       wr_acc;
  logic       wr_bad;
  logic       err_set;

  assign fs            = vsync & ~vs_d;
  assign cfg.cfg_ready = (state == ST_IDLE);
  assign wr_acc        = cfg.cfg_valid & cfg.cfg_ready;
  assign wr_bad        = wr_acc & ((cfg.cfg_prof == 2'd3) | (cfg.cfg_field == F_RSVD));
  assign sel_map       = (sel_req == 2'd3) ? 2'd0 : sel_req;
  assign err_set       = wr_bad | ((state == ST_COMMIT) & ~cand_ok);

  assign y_const    = act.y;
  assign x_min      = act.x1;
  assign x_max      = act.x2;
  assign y_min      = act.y1;
  assign y_max      = act.y2;
  assign blob_min_x = act.bx;
  assign blob_min_y = act.by;

  // Pick the staging profile requested for the next commit
  always_comb begin
    sel_set = stage[0];
    case (sel_map)
      2'd1:    sel_set = stage[1];
      2'd2:    sel_set = stage[2];
      default: sel_set = stage[0];
    endcase
  end

  mask_cfg_check #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_check (
    .x1 (sel_set.x1),
    .y1 (sel_set.y1),
    .x2 (sel_set.x2),
    .y2 (sel_set.y2),
    .ok (chk_ok)
  );

  // Frame-start edge detector and frame counter (counts every rise, even when busy)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      vs_d <= vsync;
      if (fs) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Staging bank writes; invalid profile or reserved field is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NPROF; p++) stage[p] <= PROF_DEFAULT[p];
    end else begin
      for (int p = 0; p < NPROF; p++) begin
        if (wr_acc && !wr_bad && (cfg.cfg_prof == 2'(p)))
          stage[p] <= set_field(stage[p], cfg.cfg_field, cfg.cfg_data);
      end
    end
  end

  // Commit FSM: latch and validate in CHECK, update the active set leaving COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cand       <= PROF_DEFAULT[0];
      cand_sel   <= 2'd0;
      cand_ok    <= 1'b0;
      act        <= PROF_DEFAULT[0];
      sel_active <= 2'd0;
      commit     <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fs) state <= ST_CHECK;
        end
        ST_CHECK: begin
          cand     <= sel_set;
          cand_sel <= sel_map;
          cand_ok  <= chk_ok;
          state    <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (cand_ok) begin
            act        <= cand;
            sel_active <= cand_sel;
            commit     <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= err_set | (cfg_err & ~err_clr);
  end

`ifdef MASK_CFG_READBACK_EN
  prof_t rd_set;

  // Select the staging profile addressed by the readback port
  always_comb begin
    rd_set = stage[0];
    case (rd_prof)
      2'd1:    rd_set = stage[1];
      2'd2:    rd_set = stage[2];
      default: rd_set = stage[0];
    endcase
  end

  // Registered readback; sees the pre-write value if a write lands the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= 10'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= (rd_prof == 2'd3) ? 10'd0 : get_field(rd_set, rd_field);
    end
  end
`endif

endmodule

// File: tb/tb_mask_cfg_ctrl.sv
// Directed self-checking bench for mask_cfg_ctrl.
// Readback checks are included when MASK_CFG_READBACK_EN is defined.
module tb_mask_cfg_ctrl;
  import mask_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [1:0]  sel_req;
  logic        err_clr;
  logic        cfg_err;
  logic        commit;
  logic [1:0]  sel_active;
  logic [7:0]  y_const;
  logic [9:0]  x_min, x_max, y_min, y_max;
  logic [8:0]  blob_min_x, blob_min_y;
  logic [15:0] frame_cnt;
`ifdef MASK_CFG_READBACK_EN
  logic        rd_req;
  logic [1:0]  rd_prof;
  logic [2:0]  rd_field;
  logic [9:0]  rd_data;
  logic        rd_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  mask_cfg_ctrl_if cfg_bus ();

  mask_cfg_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .sel_req    (sel_req),
    .cfg        (cfg_bus.slave),
    .err_clr    (err_clr),
    .cfg_err    (cfg_err),
    .commit     (commit),
    .sel_active (sel_active),
    .y_const    (y_const),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .blob_min_x (blob_min_x),
    .blob_min_y (blob_min_y),
    .frame_cnt  (frame_cnt)
`ifdef MASK_CFG_READBACK_EN
    ,
    .rd_req     (rd_req),
    .rd_prof    (rd_prof),
    .rd_field   (rd_field),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks the whole active set against one expected profile
  task automatic check_active(input string tag, input prof_t e, input logic [1:0] sel);
    check_output({tag, " y_const"},    32'(y_const),    32'(e.y));
    check_output({tag, " x_min"},      32'(x_min),      32'(e.x1));
    check_output({tag, " y_min"},      32'(y_min),      32'(e.y1));
    check_output({tag, " x_max"},      32'(x_max),      32'(e.x2));
    check_output({tag, " y_max"},      32'(y_max),      32'(e.y2));
    check_output({tag, " blob_min_x"}, 32'(blob_min_x), 32'(e.bx));
    check_output({tag, " blob_min_y"}, 32'(blob_min_y), 32'(e.by));
    check_output({tag, " sel_active"}, 32'(sel_active), 32'(sel));
  endtask

  // One configuration write; samples #1 after the accepting edge
  task automatic apply_stimulus(input logic [1:0] p, input logic [2:0] f,
                                input logic [9:0] d, input logic clr);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_prof  = p;
    cfg_bus.cfg_field = f;
    cfg_bus.cfg_data  = d;
    err_clr           = clr;
    @(posedge clk);
    #1;
    cfg_bus.cfg_valid = 1'b0;
    err_clr           = 1'b0;
  endtask

  // One vsync frame with cycle-exact commit timing checks
  task automatic run_frame(input string tag, input logic exp_commit);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk); #1;
    check_output({tag, " ready in CHECK"}, 32'(cfg_bus.cfg_ready), 32'd0);
    @(posedge clk); #1;
    check_output({tag, " commit early"}, 32'(commit), 32'd0);
    @(posedge clk); #1;
    check_output({tag, " commit"}, 32'(commit), 32'(exp_commit));
    exp_frames++;
    @(negedge clk);
    vsync = 1'b0;
    @(posedge clk); #1;
    check_output({tag, " commit one cycle"}, 32'(commit), 32'd0);
    check_output({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
  endtask

  prof_t exp_p0, exp_p1;

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    sel_req = 2'd0;
    err_clr = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_prof  = 2'd0;
    cfg_bus.cfg_field = 3'd0;
    cfg_bus.cfg_data  = 10'd0;
`ifdef MASK_CFG_READBACK_EN
    rd_req = 1'b0;
    rd_prof = 2'd0;
    rd_field = 3'd0;
`endif
    exp_p0 = '{y: 8'd64, x1: 10'd55, y1: 10'd60, x2: 10'd660, y2: 10'd192, bx: 9'd21, by: 9'd15};
    exp_p1 = '{y: 8'd64, x1: 10'd98, y1: 10'd96, x2: 10'd621, y2: 10'd196, bx: 9'd30, by: 9'd30};

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_active("reset", exp_p0, 2'd0);
    check_output("reset cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_output("reset cfg_err",   32'(cfg_err),   32'd0);
    check_output("reset commit",    32'(commit),    32'd0);
    check_output("reset frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] three frames with defaults");
    run_frame("t1 f1", 1'b1);
    run_frame("t1 f2", 1'b1);
    run_frame("t1 f3", 1'b1);
    check_active("t1", exp_p0, 2'd0);
    check_output("t1 frame_cnt", 32'(frame_cnt), 32'd3);

    $display("[TB] profile 1 edit and select");
    apply_stimulus(2'd1, F_X1, 10'd100, 1'b0);
    check_output("t2 err after write", 32'(cfg_err), 32'd0);
    sel_req = 2'd1;
    run_frame("t2", 1'b1);
    exp_p1.x1 = 10'd100;
    check_active("t2", exp_p1, 2'd1);

    $display("[TB] invalid window on profile 2");
    apply_stimulus(2'd2, F_X1, 10'd709, 1'b0);
    sel_req = 2'd2;
    run_frame("t3", 1'b0);
    check_active("t3 unchanged", exp_p1, 2'd1);
    check_output("t3 cfg_err", 32'(cfg_err), 32'd1);
    apply_stimulus(2'd0, F_X1, 10'd55, 1'b1);
    check_output("t3 err_clr", 32'(cfg_err), 32'd0);

    $display("[TB] dropped writes and sticky error");
    apply_stimulus(2'd0, F_RSVD, 10'd1, 1'b0);
    check_output("t4 field7 err", 32'(cfg_err), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    check_output("t4 clear", 32'(cfg_err), 32'd0);
    apply_stimulus(2'd3, F_X1, 10'd5, 1'b0);
    check_output("t4 prof3 err", 32'(cfg_err), 32'd1);
    @(posedge clk); #1;
    check_output("t4 err sticky", 32'(cfg_err), 32'd1);
    apply_stimulus(2'd0, F_RSVD, 10'd2, 1'b1);
    check_output("t4 clr plus new err", 32'(cfg_err), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    check_output("t4 clear again", 32'(cfg_err), 32'd0);
    apply_stimulus(2'd0, F_Y,  10'h3C5, 1'b0);
    apply_stimulus(2'd0, F_BX, 10'h3FF, 1'b0);
    check_output("t4 trunc no err", 32'(cfg_err), 32'd0);

    $display("[TB] write in frame-start cycle and during CHECK");
    sel_req = 2'd0;
    @(negedge clk);
    vsync = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_prof  = 2'd0;
    cfg_bus.cfg_field = F_Y2;
    cfg_bus.cfg_data  = 10'd200;
    @(posedge clk); #1;
    check_output("t5 ready CHECK", 32'(cfg_bus.cfg_ready), 32'd0);
    cfg_bus.cfg_field = F_Y1;
    cfg_bus.cfg_data  = 10'd70;
    @(posedge clk); #1;
    check_output("t5 ready COMMIT", 32'(cfg_bus.cfg_ready), 32'd0);
    @(posedge clk); #1;
    exp_frames++;
    check_output("t5 commit", 32'(commit), 32'd1);
    exp_p0.y  = 8'hC5;
    exp_p0.bx = 9'h1FF;
    exp_p0.y2 = 10'd200;
    check_active("t5", exp_p0, 2'd0);
    check_output("t5 ready back", 32'(cfg_bus.cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_bus.cfg_valid = 1'b0;
    @(negedge clk);
    vsync = 1'b0;
    sel_req = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    check_output("t5 sel mid-frame", 32'(sel_active), 32'd0);
    check_output("t5 y_min mid-frame", 32'(y_min), 32'd60);
    sel_req = 2'd3;
    run_frame("t5 sel3", 1'b1);
    exp_p0.y1 = 10'd70;
    check_active("t5 sel3", exp_p0, 2'd0);

    $display("[TB] frame start while busy");
    @(negedge clk); vsync = 1'b1;
    @(posedge clk);
    @(negedge clk); vsync = 1'b0;
    @(posedge clk);
    @(negedge clk); vsync = 1'b1;
    @(posedge clk); #1;
    exp_frames += 2;
    check_output("t5b commit", 32'(commit), 32'd1);
    check_output("t5b frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    repeat (3) @(posedge clk);
    #1;
    check_output("t5b ignored ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_output("t5b no extra commit", 32'(commit), 32'd0);
    @(negedge clk); vsync = 1'b0;

    $display("[TB] reset during COMMIT");
    sel_req = 2'd1;
    @(negedge clk); vsync = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_p0 = '{y: 8'd64, x1: 10'd55, y1: 10'd60, x2: 10'd660, y2: 10'd192, bx: 9'd21, by: 9'd15};
    check_active("t6", exp_p0, 2'd0);
    check_output("t6 commit", 32'(commit), 32'd0);
    check_output("t6 frame_cnt", 32'(frame_cnt), 32'd0);
    check_output("t6 ready", 32'(cfg_bus.cfg_ready), 32'd1);
    vsync = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("t6 no late commit", 32'(commit), 32'd0);
    check_output("t6 x_min held", 32'(x_min), 32'd55);

`ifdef MASK_CFG_READBACK_EN
    $display("[TB] readback");
    @(negedge clk);
    rd_req = 1'b1; rd_prof = 2'd1; rd_field = F_X2;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check_output("rb valid", 32'(rd_valid), 32'd1);
    check_output("rb p1 x2", 32'(rd_data), 32'd621);
    @(posedge clk); #1;
    check_output("rb valid one cycle", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rd_req = 1'b1; rd_prof = 2'd1; rd_field = F_X2;
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_prof = 2'd1;
    cfg_bus.cfg_field = F_X2; cfg_bus.cfg_data = 10'd600;
    @(posedge clk); #1;
    cfg_bus.cfg_valid = 1'b0;
    check_output("rb old value", 32'(rd_data), 32'd621);
    @(posedge clk); #1;
    check_output("rb new value", 32'(rd_data), 32'd600);
    rd_field = F_RSVD;
    @(posedge clk); #1;
    check_output("rb rsvd data", 32'(rd_data), 32'd0);
    check_output("rb rsvd valid", 32'(rd_valid), 32'd1);
    rd_prof = 2'd0; rd_field = F_Y;
    @(posedge clk); #1;
    check_output("rb p0 y", 32'(rd_data), 32'd64);
    rd_req = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
